// File: rtl/gray_code_pointer_source.sv
// Source-domain end of a gray-coded pointer crossing: owns the binary pointer,
// registers its gray copy for the destination, and derives occupancy/flags.
module gray_code_pointer_source #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             source_clock,
  input  logic             source_reset_n,
  input  logic             increment,
  input  logic [WIDTH-1:0] remote_value,
  output logic             accepted,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] gray_value,
  output logic [WIDTH-1:0] used,
  output logic [WIDTH-1:0] free,
  output logic             full,
  output logic             overflow_error,
  output logic             pointer_error
);

  localparam logic [WIDTH-1:0] CAPACITY      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] INITIAL_GRAY  = INITIAL_VALUE ^ (INITIAL_VALUE >> 1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] gray_q;
  logic             overflow_error_q;
  logic             pointer_error_q;

  logic [WIDTH-1:0] next_value;
  logic [WIDTH-1:0] next_gray;
  logic             over_capacity;

  always_comb begin
    used          = value_q - remote_value;
    full          = (used == CAPACITY);
    over_capacity = (used > CAPACITY);
    free          = over_capacity ? '0 : (CAPACITY - used);
    accepted      = increment & ~full & ~pointer_error_q;
    next_value    = value_q + WIDTH'(1);
    // Gray is derived from the next binary value so it lands in the same flop
    // stage as value; the crossing only ever sees a registered, glitch-free code.
    next_gray     = next_value ^ (next_value >> 1);
  end

  always_ff @(posedge source_clock) begin
    if (!source_reset_n) begin
      value_q          <= INITIAL_VALUE;
      gray_q           <= INITIAL_GRAY;
      overflow_error_q <= 1'b0;
      pointer_error_q  <= 1'b0;
    end else begin
      if (accepted) begin
        value_q <= next_value;
        gray_q  <= next_gray;
      end
      if (increment && full) begin
        overflow_error_q <= 1'b1;
      end
      if (over_capacity) begin
        pointer_error_q <= 1'b1;
      end
    end
  end

  assign value          = value_q;
  assign gray_value     = gray_q;
  assign overflow_error = overflow_error_q;
  assign pointer_error  = pointer_error_q;

endmodule

// File: tb/tb_gray_code_pointer_source.sv
// Bench for gray_code_pointer_source: directed scenarios then randomized
// traffic on two instances (start 0 and start 14) against an arithmetic model.
module tb_gray_code_pointer_source;

  localparam int W   = 4;
  localparam int CAP = 8;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         inc [2];
  logic [W-1:0] rem [2];
  logic         acc [2];
  logic [W-1:0] val [2];
  logic [W-1:0] gry [2];
  logic [W-1:0] usd [2];
  logic [W-1:0] fre [2];
  logic         ful [2];
  logic         oe  [2];
  logic         pe  [2];

  gray_code_pointer_source #(.WIDTH(W), .INITIAL_VALUE(4'd0)) dut_a (
    .source_clock(clk), .source_reset_n(rst_n), .increment(inc[0]),
    .remote_value(rem[0]), .accepted(acc[0]), .value(val[0]),
    .gray_value(gry[0]), .used(usd[0]), .free(fre[0]), .full(ful[0]),
    .overflow_error(oe[0]), .pointer_error(pe[0])
  );

  gray_code_pointer_source #(.WIDTH(W), .INITIAL_VALUE(4'd14)) dut_b (
    .source_clock(clk), .source_reset_n(rst_n), .increment(inc[1]),
    .remote_value(rem[1]), .accepted(acc[1]), .value(val[1]),
    .gray_value(gry[1]), .used(usd[1]), .free(fre[1]), .full(ful[1]),
    .overflow_error(oe[1]), .pointer_error(pe[1])
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: pointer as a plain integer, flags as booleans.
  int mv     [2];
  int init_v [2] = '{0, 14};
  bit moe    [2];
  bit mpe    [2];

  function automatic int m_used(int i);
    return (((mv[i] - int'(rem[i])) % 16) + 16) % 16;
  endfunction

  function automatic bit m_full(int i);
    return m_used(i) == CAP;
  endfunction

  function automatic int m_free(int i);
    return (m_used(i) > CAP) ? 0 : CAP - m_used(i);
  endfunction

  function automatic bit m_acc(int i);
    return inc[i] && !m_full(i) && !mpe[i];
  endfunction

  function automatic int to_gray(int b);
    return b ^ (b / 2);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(int i);
    chk($sformatf("value%0d", i),    32'(val[i]), 32'(mv[i]));
    chk($sformatf("gray%0d", i),     32'(gry[i]), 32'(to_gray(mv[i])));
    chk($sformatf("used%0d", i),     32'(usd[i]), 32'(m_used(i)));
    chk($sformatf("free%0d", i),     32'(fre[i]), 32'(m_free(i)));
    chk($sformatf("full%0d", i),     32'(ful[i]), 32'(m_full(i)));
    chk($sformatf("accepted%0d", i), 32'(acc[i]), 32'(m_acc(i)));
    chk($sformatf("overflow%0d", i), 32'(oe[i]),  32'(moe[i]));
    chk($sformatf("ptrerr%0d", i),   32'(pe[i]),  32'(mpe[i]));
  endtask

  task automatic settle_check();
    #1;
    check_all(0);
    check_all(1);
  endtask

  // Advance one clock: model next state from current inputs, then compare
  // gray step size across the edge (reset edges excluded).
  task automatic tick();
    int         nv   [2];
    bit         noe  [2];
    bit         npe  [2];
    logic [W-1:0] prev [2];
    bit         in_reset;
    in_reset = !rst_n;
    for (int i = 0; i < 2; i++) begin
      prev[i] = gry[i];
      if (in_reset) begin
        nv[i] = init_v[i]; noe[i] = 1'b0; npe[i] = 1'b0;
      end else begin
        nv[i]  = m_acc(i) ? (mv[i] + 1) % 16 : mv[i];
        noe[i] = moe[i] || (inc[i] && m_full(i));
        npe[i] = mpe[i] || (m_used(i) > CAP);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mv[i] = nv[i]; moe[i] = noe[i]; mpe[i] = npe[i];
    end
    @(negedge clk);
    if (!in_reset) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("gray_step%0d", i), 32'($countones(prev[i] ^ gry[i]) <= 1), 32'(1));
    end
  endtask

  int gseq_a [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
  int gseq_b [3] = '{8, 0, 1};

  initial begin
    rst_n = 1'b0;
    inc   = '{1'b0, 1'b0};
    rem   = '{4'd0, 4'd14};
    mv    = '{0, 14};
    moe   = '{1'b0, 1'b0};
    mpe   = '{1'b0, 1'b0};
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    settle_check();
    chk("rst_value", 32'(val[0]), 32'd0);
    chk("rst_free",  32'(fre[0]), 32'd8);
    chk("rst_gray_b", 32'(gry[1]), 32'd9);

    // Eight back-to-back increments on A; three on B to cross the wrap.
    for (int k = 0; k < 8; k++) begin
      inc[0] = 1'b1;
      inc[1] = (k < 3);
      settle_check();
      tick();
      chk("gray_seq_a", 32'(gry[0]), 32'(gseq_a[k]));
      chk("value_seq_a", 32'(val[0]), 32'(k + 1));
      if (k < 3) chk("gray_seq_b", 32'(gry[1]), 32'(gseq_b[k]));
    end
    inc[1] = 1'b0;
    chk("full_after_8", 32'(ful[0]), 32'd1);
    chk("wrap_used_b", 32'(usd[1]), 32'd3);

    // Increment held while full.
    for (int k = 0; k < 2; k++) begin
      inc[0] = 1'b1;
      settle_check();
      tick();
      chk("hold_value", 32'(val[0]), 32'd8);
      chk("overflow_set", 32'(oe[0]), 32'd1);
    end

    inc[0] = 1'b0;
    rem[0] = 4'd3;
    settle_check();
    chk("drain_used", 32'(usd[0]), 32'd5);
    chk("drain_free", 32'(fre[0]), 32'd3);
    inc[0] = 1'b1;
    settle_check();
    chk("resume_acc", 32'(acc[0]), 32'd1);
    tick();

    // Walk A to 12, then present a corrupt remote.
    rem[0] = 4'd9;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      tick();
    end
    inc[0] = 1'b0;
    rem[0] = 4'd0;
    settle_check();
    chk("perr_not_yet", 32'(pe[0]), 32'd0);
    tick();
    chk("perr_set", 32'(pe[0]), 32'd1);
    inc[0] = 1'b1;
    settle_check();
    chk("perr_refuse", 32'(acc[0]), 32'd0);
    tick();
    chk("perr_hold", 32'(val[0]), 32'd12);

    // Reset mid-stream with increment asserted.
    rst_n = 1'b0;
    settle_check();
    tick();
    chk("mid_rst_value", 32'(val[0]), 32'd0);
    chk("mid_rst_oe", 32'(oe[0]), 32'd0);
    chk("mid_rst_pe", 32'(pe[0]), 32'd0);
    rst_n = 1'b1;
    settle_check();
    tick();
    chk("post_rst_value", 32'(val[0]), 32'd1);

    // Randomized traffic with occasional corrupt remotes and resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < 2; i++) begin
        inc[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) < 2)
          rem[i] = W'($urandom_range(0, 15));
        else if ($urandom_range(0, 3) == 0)
          rem[i] = W'((mv[i] - int'($urandom_range(0, CAP)) + 16) % 16);
      end
      settle_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gray_code_pointer_source.md
Name: gray_code_pointer_source

Overview:
- Source-domain end of a gray-coded pointer crossing. It owns the binary pointer, advances it on accepted increments, and drives a registered gray-code copy that changes at most one bit per cycle.
- The gray output is the value sampled by a gray_code_chain in the destination domain.
- Takes back the destination's pointer, already captured and de-grayed into this domain by a gray_code_chain, to compute occupancy, full, free space and error flags.
- Typical use: write-pointer side of an async FIFO, or the credit-issuing side of any pointer handshake.

Parameters:
- WIDTH, 4: pointer width in bits, including the wrap bit. CAPACITY = 2**(WIDTH-1). Legal range 2..32.
- INITIAL_VALUE, WIDTH'(0): binary pointer value after reset. Must match INITIAL_VALUE of both crossing chains.

Ports:
- source_clock  input  1  sole clock.
- source_reset_n  input  1  synchronous, active-low reset.
- increment  input  1  request to advance the pointer by one.
- remote_value  input  WIDTH  binary remote pointer, already synchronised and de-grayed into source_clock.
- accepted  output  1  increment taken this cycle.
- value  output  WIDTH  current binary pointer.
- gray_value  output  WIDTH  registered gray code of value; the only signal that crosses domains.
- used  output  WIDTH  (value - remote_value) mod 2**WIDTH.
- free  output  WIDTH  CAPACITY - used, saturating at 0 when used > CAPACITY.
- full  output  1  used == CAPACITY.
- overflow_error  output  1  sticky: increment requested while full.
- pointer_error  output  1  sticky: used > CAPACITY observed.

Behaviour:
- Reset is synchronous and active-low, sampled on the posedge of source_clock, and overrides all other activity. At reset:
  - value = INITIAL_VALUE
  - gray_value = INITIAL_VALUE ^ (INITIAL_VALUE >> 1)
  - overflow_error = 0, pointer_error = 0
  - used, free and full follow combinationally from the new value and remote_value.
- accepted = increment & ~full & ~pointer_error. Combinational, same cycle as the request.
- On an accepted increment, at the next edge:
  - value <= value + 1, mod 2**WIDTH.
  - gray_value <= gray(value + 1), computed from the next binary value and registered in the same flop stage as value.
  - gray_value never comes from combinational logic at the output; no glitches reach the crossing.
- Without an accepted increment, value and gray_value hold.
- Invariant: gray_value == gray(value) every cycle. Consecutive gray_value samples differ in at most one bit.
- Wrap-around: value goes from 2**WIDTH-1 to 0; gray_value goes from 100..0 to 000..0 (single bit).
- used, free and full are combinational from the value register and the remote_value input. Latency from an accepted increment to the used update is 1 cycle.
- A remote_value change is reflected in used, free and full in the same cycle it arrives.
- Increment while full:
  - accepted = 0, pointer unchanged.
  - overflow_error is set at the next edge and held until reset.
- used > CAPACITY (corrupt or mismatched remote):
  - pointer_error is set at the next edge and held until reset.
  - While pointer_error is set, all increments are refused. full is not forced.
- A simultaneous accepted increment and remote_value change are independent. Next-cycle used = (value+1) - new remote_value.
- No handshake on remote_value: it may move by any amount per cycle, and the block never blocks on it.

Test Plan:
- Reset with WIDTH=4, INITIAL_VALUE=0, remote_value=0 -> value=0, gray_value=0000, used=0, free=8, full=0, both errors 0.
- 8 back-to-back increments, remote_value=0 -> value sequence 1..8, gray_value 0001,0011,0010,0110,0111,0101,0100,1100, full=1 after the 8th. Each gray_value step flips exactly one bit.
- Full, then increment held 2 cycles -> accepted=0, value stays 8, overflow_error=1 from the next cycle and stays 1. Then remote_value=3 -> used=5, free=3, full=0, next increment accepted.
- Wrap: INITIAL_VALUE=14, remote_value=14, 3 increments -> value 15,0,1, gray_value 1000,0000,0001, used=3.
- remote_value=0 while value=12 -> used=12 > 8, pointer_error=1 next cycle, subsequent increments refused.
- Reset asserted mid-stream while increment=1 -> no advance at that edge, value=INITIAL_VALUE, errors cleared, increments resume the cycle after reset deasserts.
